// File: rtl/simmem_resp_bank.sv
// -----------------------------------------------------------------------------
// simmem_resp_bank
//
// Response buffer that sits downstream of the simulated-memory releaser. It
// holds responses (read data or write responses) coming back from the real
// memory. A response is offered to the requester only once the releaser has
// raised the release enable for that response's AXI ID. Responses that share
// an ID leave in arrival order. Responses with different IDs may overtake
// each other.
//
// Each slot stores a rank: the number of older valid entries with the same ID.
// Only a rank-0 entry can be offered. This keeps per-ID order without
// searching by age at output time.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous, active-high reset
//   in_valid_i     incoming response valid
//   in_ready_o     bank can accept a response (registered state only)
//   in_data_i      incoming response, ID in bits [IDWidth-1:0]
//   release_en_i   per-ID release enable from the releaser
//   out_valid_o    released response valid
//   out_ready_i    requester ready
//   out_data_o     released response (0 when nothing is selected)
//   released_cnt_o count of output handshakes
//
// Optional feature:
//   SIMMEM_RESP_BANK_STATS_EN - when defined, released_cnt_o counts output
//   handshakes and saturates at 2**32-1. When undefined, released_cnt_o is
//   tied to 0.
// -----------------------------------------------------------------------------
module simmem_resp_bank #(
  parameter int DataWidth = 64,
  parameter int IDWidth   = 4,
  parameter int Capacity  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DataWidth-1:0]   in_data_i,
  input  logic [2**IDWidth-1:0]  release_en_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DataWidth-1:0]   out_data_o,
  output logic [31:0]            released_cnt_o
);

  localparam int IdxW = (Capacity > 1) ? $clog2(Capacity) : 1;
  localparam int CntW = $clog2(Capacity + 1);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  function automatic logic [IDWidth-1:0] id_of(input logic [DataWidth-1:0] d);
    return d[IDWidth-1:0];
  endfunction

  // Slot storage
  logic [Capacity-1:0]  valid_q, valid_d;
  logic [DataWidth-1:0] data_q [Capacity];
  logic [IdxW-1:0]      rank_q [Capacity];
  logic [IdxW-1:0]      rank_d [Capacity];

  // Output FSM
  state_e          state_q, state_d;
  logic [IdxW-1:0] hold_idx_q, hold_idx_d;

  // Combinational helpers
  logic [CntW-1:0]  valid_cnt;
  logic [CntW-1:0]  same_id_cnt;
  logic             any_elig;
  logic [IdxW-1:0]  win_idx;
  logic             any_free;
  logic [IdxW-1:0]  free_idx;
  logic [IdxW-1:0]  sel_idx;
  logic [IDWidth-1:0] out_id;
  logic [IDWidth-1:0] in_id;
  logic             out_fire;
  logic             in_fire;
  logic [CntW-1:0]  new_rank;

  assign in_id = id_of(in_data_i);

  // Occupancy, same-ID count for the incoming response, winner and free slot.
  // NOTE: every variable written in an always_comb block gets a default first,
  //       so no path can leave it unassigned and infer a latch.
  always_comb begin
    valid_cnt   = '0;
    same_id_cnt = '0;
    any_elig    = 1'b0;
    win_idx     = '0;
    any_free    = 1'b0;
    free_idx    = '0;
    for (int i = 0; i < Capacity; i++) begin
      valid_cnt = valid_cnt + CntW'(valid_q[i]);
      if (valid_q[i] && (id_of(data_q[i]) == in_id)) begin
        same_id_cnt = same_id_cnt + CntW'(1);
      end
      // Lowest eligible index wins.
      if (!any_elig && valid_q[i] && (rank_q[i] == '0) &&
          release_en_i[id_of(data_q[i])]) begin
        any_elig = 1'b1;
        win_idx  = IdxW'(i);
      end
      // The slot search uses registered valid bits only, so a slot freed in
      // this cycle is never reused in the same cycle.
      if (!any_free && !valid_q[i]) begin
        any_free = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end

  // A full bank refuses input even when an output leaves in the same cycle.
  assign in_ready_o = (valid_cnt < CntW'(Capacity));
  assign in_fire    = in_valid_i && in_ready_o;

  // Output FSM: next state and outputs
  always_comb begin
    state_d     = state_q;
    hold_idx_d  = hold_idx_q;
    out_valid_o = 1'b0;
    sel_idx     = '0;
    unique case (state_q)
      IDLE: begin
        out_valid_o = any_elig;
        sel_idx     = win_idx;
        if (any_elig && !out_ready_i) begin
          // Freeze the offer so that data stays stable until it is accepted.
          state_d    = HOLD;
          hold_idx_d = win_idx;
        end
      end
      HOLD: begin
        out_valid_o = 1'b1;
        sel_idx     = hold_idx_q;
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_fire   = out_valid_o && out_ready_i;
  assign out_id     = id_of(data_q[sel_idx]);
  assign out_data_o = out_valid_o ? data_q[sel_idx] : '0;

  // Rank of the arriving entry. If a same-ID entry leaves in this cycle, that
  // entry is still counted above, so one is subtracted for it.
  assign new_rank = same_id_cnt - CntW'(out_fire && (out_id == in_id));

  // Slot next state
  always_comb begin
    valid_d = valid_q;
    rank_d  = rank_q;
    if (out_fire) begin
      valid_d[sel_idx] = 1'b0;
      for (int i = 0; i < Capacity; i++) begin
        if (valid_q[i] && (IdxW'(i) != sel_idx) &&
            (id_of(data_q[i]) == out_id) && (rank_q[i] != '0)) begin
          rank_d[i] = rank_q[i] - IdxW'(1);
        end
      end
    end
    if (in_fire) begin
      valid_d[free_idx] = 1'b1;
      rank_d[free_idx]  = IdxW'(new_rank);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  //       samples values from before the edge regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      state_q    <= IDLE;
      hold_idx_q <= '0;
      for (int i = 0; i < Capacity; i++) begin
        rank_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      state_q    <= state_d;
      hold_idx_q <= hold_idx_d;
      rank_q     <= rank_d;
    end
  end

  // NOTE: the data array has no reset. A slot's contents are only observed
  //       while its valid bit is set, and every valid bit is reset.
  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      data_q[free_idx] <= in_data_i;
    end
  end

`ifdef SIMMEM_RESP_BANK_STATS_EN
  logic [31:0] released_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      released_cnt_q <= '0;
    end else if (out_fire && (released_cnt_q != '1)) begin
      released_cnt_q <= released_cnt_q + 32'd1;
    end
  end

  assign released_cnt_o = released_cnt_q;
`else
  assign released_cnt_o = '0;
`endif

endmodule

// File: tb/tb_simmem_resp_bank.sv
// -----------------------------------------------------------------------------
// Testbench for simmem_resp_bank (DataWidth=64, IDWidth=4, Capacity=16).
//
// The reference model stores responses as a slot array with arrival sequence
// numbers. A slot is eligible when its ID is enabled and no older valid entry
// has the same ID. Among eligible slots, the lowest index wins. A held offer
// persists until it is accepted.
// -----------------------------------------------------------------------------
module tb_simmem_resp_bank;

  localparam int DW  = 64;
  localparam int IW  = 4;
  localparam int CAP = 16;
  localparam int NID = 2**IW;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic [NID-1:0] release_en;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic [31:0]    released_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  simmem_resp_bank #(.DataWidth(DW), .IDWidth(IW), .Capacity(CAP)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .release_en_i   (release_en),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .released_cnt_o (released_cnt)
  );

  // ---------------- reference model ----------------
  bit          m_valid [CAP];
  logic [DW-1:0] m_data [CAP];
  int unsigned m_seq   [CAP];
  int unsigned seq_ctr = 0;
  bit          m_hold  = 0;
  int          m_hold_idx = 0;
  longint      m_cnt   = 0;

  bit            exp_valid;
  int            exp_sel;
  logic [DW-1:0] exp_data;
  bit            exp_ready;
  logic [31:0]   exp_cnt;

  function automatic logic [IW-1:0] idf(input logic [DW-1:0] d);
    return d[IW-1:0];
  endfunction

  function automatic logic [DW-1:0] mk(input int id);
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    d[IW-1:0] = IW'(id);
    return d;
  endfunction

  task automatic model_eval();
    int win;
    int cnt;
    win = -1;
    cnt = 0;
    for (int i = 0; i < CAP; i++) begin
      if (m_valid[i]) cnt++;
      if (win < 0 && m_valid[i] && release_en[idf(m_data[i])]) begin
        bit older;
        older = 0;
        for (int j = 0; j < CAP; j++)
          if (m_valid[j] && idf(m_data[j]) == idf(m_data[i]) && m_seq[j] < m_seq[i])
            older = 1;
        if (!older) win = i;
      end
    end
    if (m_hold) begin
      exp_valid = 1;
      exp_sel   = m_hold_idx;
    end else begin
      exp_valid = (win >= 0);
      exp_sel   = win;
    end
    exp_data  = exp_valid ? m_data[exp_sel] : '0;
    exp_ready = (cnt < CAP);
`ifdef SIMMEM_RESP_BANK_STATS_EN
    exp_cnt = 32'(m_cnt);
`else
    exp_cnt = 32'd0;
`endif
  endtask

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < CAP; i++) m_valid[i] = 0;
      m_hold = 0;
      m_cnt  = 0;
    end else begin
      int  free;
      bit  fire;
      bit  acc;
      free = -1;
      for (int i = CAP - 1; i >= 0; i--) if (!m_valid[i]) free = i;
      fire = exp_valid && out_ready;
      acc  = in_valid && exp_ready;
      if (fire) begin
        m_valid[exp_sel] = 0;
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      end
      if (m_hold && out_ready) m_hold = 0;
      else if (!m_hold && exp_valid && !out_ready) begin
        m_hold     = 1;
        m_hold_idx = exp_sel;
      end
      if (acc) begin
        m_valid[free] = 1;
        m_data[free]  = in_data;
        m_seq[free]   = seq_ctr++;
      end
    end
  endtask

  // Apply inputs after the falling edge, then compute model expectations.
  task automatic drive(input bit r, input bit iv, input logic [DW-1:0] d,
                       input logic [NID-1:0] rel, input bit ordy);
    @(negedge clk);
    rst        = r;
    in_valid   = iv;
    in_data    = d;
    release_en = rel;
    out_ready  = ordy;
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    drive(0, 0, '0, '0, 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [DW-1:0] d;
    drive(1, 0, '0, '0, 0); tick();
    drive(1, 0, '0, '0, 0); tick();
    idle_cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_cmp++; if (released_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", released_cnt); end
    tick();
    // Load 3 responses, release one of them, then reset mid-traffic.
    for (int k = 0; k < 3; k++) begin
      d = mk(k + 1);
      drive(0, 1, d, '0, 0); tick();
    end
    drive(0, 0, '0, NID'(1) << 1, 1); tick();
    drive(1, 0, '0, '0, 0); tick();
    drive(0, 0, '0, '1, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (released_cnt !== 32'd0) begin n_err++; $display("FAIL midreset_cnt got %0d want 0", released_cnt); end
    tick();
    // A fresh response must be the only one that comes out.
    d = mk(2);
    drive(0, 1, d, '1, 1); tick();
    drive(0, 0, '0, '1, 1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== d) begin n_err++; $display("FAIL postreset_out got v=%b d=%h want v=1 d=%h", out_valid, out_data, d); end
    tick();
    drive(0, 0, '0, '1, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL postreset_empty got %b want 0", out_valid); end
    tick();
  endtask

  task automatic test_order();
    logic [DW-1:0] a, b, c;
    logic [NID-1:0] en2, en25;
    a = mk(2); b = mk(2); c = mk(5);
    en2  = NID'(1) << 2;
    en25 = en2 | (NID'(1) << 5);
    drive(0, 1, a, en2, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL order_latency got %b want 0", out_valid); end
    tick();
    drive(0, 1, b, en2, 1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== a) begin n_err++; $display("FAIL order_a got v=%b d=%h want %h", out_valid, out_data, a); end
    tick();
    drive(0, 1, c, en2, 1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== b) begin n_err++; $display("FAIL order_b got v=%b d=%h want %h", out_valid, out_data, b); end
    tick();
    drive(0, 0, '0, en2, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL order_c_held got %b want 0", out_valid); end
    tick();
    drive(0, 0, '0, en25, 1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== c) begin n_err++; $display("FAIL order_c got v=%b d=%h want %h", out_valid, out_data, c); end
    tick();
    drive(0, 0, '0, en25, 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL order_empty got %b want 0", out_valid); end
    tick();
  endtask

  task automatic test_full();
    logic [DW-1:0] d0, d;
    d0 = mk($urandom_range(0, NID - 1));
    for (int k = 0; k < CAP; k++) begin
      d = (k == 0) ? d0 : mk($urandom_range(0, NID - 1));
      drive(0, 1, d, '0, 0);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_fill_ready k=%0d got %b want 1", k, in_ready); end
      tick();
    end
    d = mk(idf(d0));
    drive(0, 1, d, NID'(1) << idf(d0), 1);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== d0) begin n_err++; $display("FAIL full_out got v=%b d=%h want %h", out_valid, out_data, d0); end
    tick();
    idle_cycle();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_after got %b want 1", in_ready); end
    tick();
    // Drain against the model; an entry accepted while full would show up here.
    for (int k = 0; k < CAP + 2; k++) begin
      drive(0, 0, '0, '1, 1);
      n_cmp++; if (out_valid !== exp_valid || out_data !== exp_data) begin n_err++; $display("FAIL full_drain k=%0d got v=%b d=%h want v=%b d=%h", k, out_valid, out_data, exp_valid, exp_data); end
      tick();
    end
  endtask

  task automatic test_hold();
    logic [DW-1:0] x, y;
    x = mk(1); y = mk(0);
    drive(0, 1, x, NID'(1) << 1, 0); tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) drive(0, 0, '0, NID'(1) << 1, 0);
      else if (k == 2) drive(0, 1, y, NID'(1), 0);
      else drive(0, 0, '0, NID'(1), 0);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== x) begin n_err++; $display("FAIL hold_stable k=%0d got v=%b d=%h want %h", k, out_valid, out_data, x); end
      tick();
    end
    drive(0, 0, '0, NID'(1), 1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== x) begin n_err++; $display("FAIL hold_release got v=%b d=%h want %h", out_valid, out_data, x); end
    tick();
    drive(0, 0, '0, NID'(1), 1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== y) begin n_err++; $display("FAIL hold_next got v=%b d=%h want %h", out_valid, out_data, y); end
    tick();
    drive(0, 0, '0, NID'(1), 1);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_empty got %b want 0", out_valid); end
    tick();
  endtask

  task automatic test_same_id();
    logic [DW-1:0] p, q;
    p = mk(3); q = mk(3);
    drive(0, 1, p, '0, 1); tick();
    drive(0, 1, q, NID'(1) << 3, 1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== p) begin n_err++; $display("FAIL same_id_first got v=%b d=%h want %h", out_valid, out_data, p); end
    tick();
    drive(0, 0, '0, NID'(1) << 3, 1);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== q) begin n_err++; $display("FAIL same_id_second got v=%b d=%h want %h", out_valid, out_data, q); end
    tick();
  endtask

  task automatic test_random();
    bit r;
    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(0, 149) == 0);
      drive(r, $urandom_range(0, 2) != 0, mk($urandom_range(0, 3)),
            NID'($urandom), $urandom_range(0, 3) != 0);
      n_cmp++;
      if (out_valid !== exp_valid || out_data !== exp_data ||
          in_ready !== exp_ready || released_cnt !== exp_cnt) begin
        n_err++;
        $display("FAIL random k=%0d got v=%b d=%h r=%b c=%0d want v=%b d=%h r=%b c=%0d",
                 k, out_valid, out_data, in_ready, released_cnt,
                 exp_valid, exp_data, exp_ready, exp_cnt);
      end
      tick();
    end
  endtask

  task automatic test_stats();
    logic [31:0] want;
    drive(1, 0, '0, '0, 0); tick();
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, mk($urandom_range(0, NID - 1)), '1, 1); tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, '0, '1, 1); tick();
    end
    idle_cycle();
`ifdef SIMMEM_RESP_BANK_STATS_EN
    want = 32'd10;
`else
    want = 32'd0;
`endif
    n_cmp++; if (released_cnt !== want) begin n_err++; $display("FAIL stats_count got %0d want %0d", released_cnt, want); end
    n_cmp++; if (released_cnt !== exp_cnt) begin n_err++; $display("FAIL stats_model got %0d want %0d", released_cnt, exp_cnt); end
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; release_en = '0; out_ready = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      m_valid[i] = 0; m_data[i] = '0; m_seq[i] = 0;
    end
    test_reset();
    test_order();
    test_full();
    test_hold();
    test_same_id();
    test_random();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
